// File: rtl/ctrl_pkg.sv
// Shared types for the I2S transmit serializer: slot format, control state and slot-width helper.
package ctrl_pkg;

    typedef enum logic {
        f16bits = 1'b0,
        f32bits = 1'b1
    } frame_size_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

    function automatic logic [5:0] slot_width(input frame_size_t fs);
        case (fs)
            f16bits: return 6'd16;
            f32bits: return 6'd32;
            default: return 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/i2s_ws_counter.sv
// Bit counter and word-select generator; flags the last bit of each slot.
module i2s_ws_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       run,
    input  logic       stop,
    input  logic [4:0] width_m1,
    output logic       ws,
    output logic       slot_end
);

    logic [4:0] cnt_r;
    logic       ws_r;

    // slot countdown; ws toggles at every slot boundary except the closing one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 5'd0;
            ws_r  <= 1'b1;
        end else if (start) begin
            cnt_r <= width_m1;
            ws_r  <= 1'b0;
        end else if (run) begin
            if (cnt_r == 5'd0) begin
                if (stop) begin
                    cnt_r <= 5'd0;
                    ws_r  <= 1'b1;
                end else begin
                    cnt_r <= width_m1;
                    ws_r  <= ~ws_r;
                end
            end else begin
                cnt_r <= cnt_r - 5'd1;
            end
        end else begin
            cnt_r <= cnt_r;
            ws_r  <= ws_r;
        end
    end

    assign ws       = ws_r;
    assign slot_end = run && (cnt_r == 5'd0);

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: FIFO pop, MSB-first shifting with one-bit delay, underrun flag.
// Define TX_UNDERRUN_REPEAT_EN to resend the last word of the same channel on underrun.
module i2s_tx_serializer
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  frame_size_t       frame_size,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    output logic              ws,
    output logic              sd,
    output logic              busy,
    output logic              underrun,
    input  logic              underrun_clr
);

    tx_state_t         state_r;
    frame_size_t       frame_r;
    logic [DATA_W-1:0] shift_r;
    logic              sd_r;
    logic              fifo_rd_r;
    logic              busy_r;
    logic              underrun_r;

    frame_size_t       fs_s;
    logic [4:0]        width_m1_s;
    logic [4:0]        msb_idx_s;
    logic [DATA_W-1:0] word_s;
    logic [DATA_W-1:0] fill_s;
    logic              ws_s;
    logic              slot_end_s;
    logic              start_s;
    logic              stop_s;
    logic              load_s;
    logic              run_s;

    assign run_s      = (state_r == RUN);
    assign start_s    = (state_r == IDLE) && en && !fifo_empty;
    assign stop_s     = slot_end_s && ws_s && !en;
    assign load_s     = slot_end_s && !stop_s;
    assign fs_s       = run_s ? frame_r : frame_size;
    assign width_m1_s = 5'(slot_width(fs_s) - 6'd1);
    assign msb_idx_s  = 5'(slot_width(frame_r) - 6'd1);

    // word taken from the FIFO, upper bits cleared for 16-bit slots
    always_comb begin
        word_s = fifo_data;
        if (fs_s == f16bits) begin
            word_s[DATA_W-1:16] = '0;
        end else begin
            word_s = fifo_data;
        end
    end

    i2s_ws_counter u_ws_counter (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s),
        .run      (run_s),
        .stop     (stop_s),
        .width_m1 (width_m1_s),
        .ws       (ws_s),
        .slot_end (slot_end_s)
    );

`ifdef TX_UNDERRUN_REPEAT_EN
    logic [DATA_W-1:0] hist_left_r;
    logic [DATA_W-1:0] hist_right_r;

    // last word popped per channel; ws low now means the next slot is right
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_left_r  <= '0;
            hist_right_r <= '0;
        end else if (start_s) begin
            hist_left_r <= word_s;
        end else if (load_s && !fifo_empty) begin
            if (ws_s) begin
                hist_left_r <= word_s;
            end else begin
                hist_right_r <= word_s;
            end
        end else begin
            hist_left_r  <= hist_left_r;
            hist_right_r <= hist_right_r;
        end
    end

    // underrun fill is the history of the channel about to start
    always_comb begin
        fill_s = '0;
        if (ws_s) begin
            fill_s = hist_left_r;
        end else begin
            fill_s = hist_right_r;
        end
    end
`else
    // underrun fill is silence
    always_comb begin
        fill_s = '0;
    end
`endif

    // control state, shifter and registered line outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            frame_r    <= f16bits;
            shift_r    <= '0;
            sd_r       <= 1'b0;
            fifo_rd_r  <= 1'b0;
            busy_r     <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            sd_r       <= shift_r[msb_idx_s];
            fifo_rd_r  <= start_s || (load_s && !fifo_empty);
            underrun_r <= (load_s && fifo_empty) || (underrun_r && !underrun_clr);
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r <= RUN;
                        frame_r <= frame_size;
                        shift_r <= word_s;
                        busy_r  <= 1'b1;
                    end else begin
                        shift_r <= shift_r << 1;
                    end
                end
                RUN: begin
                    if (stop_s) begin
                        state_r <= IDLE;
                        shift_r <= '0;
                        busy_r  <= 1'b0;
                    end else if (load_s) begin
                        shift_r <= fifo_empty ? fill_s : word_s;
                    end else begin
                        shift_r <= shift_r << 1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd  = fifo_rd_r;
    assign ws       = ws_s;
    assign sd       = sd_r;
    assign busy     = busy_r;
    assign underrun = underrun_r;

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- I2S transmit back-end on the serial-clock side; consumes parallel words from the TX FIFO and drives the I2S line (ws, sd).
- Generates word-select, serialises MSB-first with the standard one-bit I2S delay, and alternates left and right channels.
- Detects FIFO underrun.
- Single clock domain; the FIFO read port it drives is first-word-fall-through and synchronous to clk.

Parameters:
DATA_W, 32, FIFO word width; the largest supported slot width.

Ports:
clk  in  1  serial bit clock; all logic on posedge.
rst  in  1  asynchronous reset, active-high.
en  in  1  transmit enable; level.
frame_size  in  frame_size_t  f16bits or f32bits; latched on IDLE->RUN.
fifo_data  in  DATA_W  head word of TX FIFO; valid while !fifo_empty.
fifo_empty  in  1  TX FIFO empty.
fifo_rd  out  1  one-cycle pop strobe.
ws  out  1  word select; 0 = left, 1 = right.
sd  out  1  serial data.
busy  out  1  high while in RUN.
underrun  out  1  sticky underrun flag.
underrun_clr  in  1  clears underrun.

Behaviour:
Reset values (async, immediate, also mid-frame):
- ws = 1, sd = 0, fifo_rd = 0, busy = 0, underrun = 0.
- Shift register = 0, cnt = 0, state = IDLE.

Slot width and data selection:
- Slot width W = 16 (f16bits) or 32 (f32bits).
- Word source is fifo_data[W-1:0]; the MSB is bit W-1.

State machine (IDLE, RUN):
- IDLE: ws held 1, busy 0, sd outputs the previous shift MSB, then 0.
- IDLE -> RUN when en = 1 and !fifo_empty (start waits for data, so no start-up underrun). On that edge:
  - latch W;
  - ws <= 0;
  - load the shift register from fifo_data;
  - fifo_rd = 1 for that cycle;
  - cnt <= W-1;
  - busy <= 1.
- RUN, cnt != 0: shift left by one, cnt <= cnt - 1.
- RUN, cnt == 0 (slot boundary):
  - ws <= ~ws;
  - cnt <= W-1;
  - load the next word with a fifo_rd pulse, or take the underrun path.
- RUN -> IDLE only at a right-slot end (cnt == 0, ws == 1) with en == 0. ws stays 1; no fifo_rd. A disable never truncates a frame.

sd timing:
- sd is registered: sd <= shift[W-1] every cycle.
- The MSB of a slot's word appears on sd one clk after the ws edge that opens that slot.
- The LSB appears in the first bit of the following slot (I2S one-bit delay).

fifo_rd rules:
- Asserted only on a load edge with !fifo_empty.
- Never asserted two cycles in a row; maximum one pop per W cycles.

Underrun (slot boundary with fifo_empty = 1):
- No pop; shift register loads 0; underrun <= 1.
- underrun stays set until underrun_clr = 1. If set and clear coincide, set wins.

frame_size:
- Changes during RUN are ignored until the next IDLE->RUN.

en during RUN:
- en = 0 mid-frame: the current frame completes. If the FIFO is non-empty, the pending right word is still popped and sent.
- en = 1 again before the right-slot end: RUN continues seamlessly.

Optional Feature:
Macro TX_UNDERRUN_REPEAT_EN.
- Defined: on underrun, the shift register reloads the last word successfully popped for the same channel (left/right history kept separately; zero after reset). underrun is still flagged.
- Undefined: underrun transmits zeros; no history registers exist.

Decomposition:
- ctrl_pkg holds:
  - frame_size_t (f16bits, f32bits);
  - state enum tx_state_t (IDLE, RUN);
  - a function slot_width(frame_size_t) returning 16 or 32.
- One natural sub-module: i2s_ws_counter. It owns cnt and ws, and outputs slot_end and left/right.
- i2s_tx_serializer keeps the shift register, FIFO handshake, underrun logic and state.

Test Plan:
1. f16bits, FIFO holds 0x0000_1234 then 0x0000_ABCD, en = 1:
   - ws falls with one fifo_rd pulse;
   - sd over the next 16 clks = 0x1234 MSB-first;
   - ws rises after 16 clks, second pop, sd = 0xABCD from the clk after.
2. f32bits, words 0x8000_0001 and 0xFFFF_0000:
   - ws period 64 clks;
   - sd = 1, then 30 zeros, then 1 for the left slot; the right slot follows with exact one-bit delay.
3. Underrun: one word loaded, FIFO empty at the next boundary:
   - right slot sd = all 0, no fifo_rd, underrun = 1;
   - underrun_clr with no new underrun -> 0;
   - with TX_UNDERRUN_REPEAT_EN, the right slot repeats the last right word (0 after reset).
4. en dropped mid-left-slot:
   - right slot still sent;
   - IDLE entered exactly at the right-slot end;
   - ws stays 1, busy 0;
   - no further fifo_rd.
5. rst pulsed mid-slot (cnt = 7):
   - ws = 1, sd = 0, busy = 0, underrun = 0 immediately, without waiting for a clk edge;
   - restart after rst is clean (scenario 1 passes again).
6. frame_size toggled f16 -> f32 during RUN: slot stays 16 clks until the next IDLE->RUN; the next start uses 32.
